// File: rtl/inner_loop_sched_pkg.sv
// Shared constants and state encoding for the radix-78 inner-loop digit scheduler.
package inner_loop_pkg;

    localparam int SIZE    = 3072;
    localparam int RADIX   = 78;
    localparam int OPW     = SIZE + 2;
    localparam int NDIG    = (OPW + RADIX - 1) / RADIX;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 4;
    localparam int IDX_W   = $clog2(NDIG);
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int FL_W    = $clog2(LAT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FLUSH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/inner_loop_sched_if.sv
// Controller / accumulator / inner-loop signal bundle of the digit scheduler.
// INNER_SCHED_PERF_EN adds the perf_stall HOLD-cycle counter.
interface inner_loop_sched_if;
    import inner_loop_pkg::*;

    logic             start;
    logic             abort;
    logic [OPW-1:0]   a_in;
    logic [OPW-1:0]   b_in;
    logic             acc_ready;
    logic             loop_en_out;
    logic             loop_en;
    logic [RADIX-1:0] loop_bi;
    logic [OPW-1:0]   loop_a;
    logic             acc_valid;
    logic [IDX_W-1:0] acc_idx;
    logic             busy;
    logic             done;
    logic             error;
`ifdef INNER_SCHED_PERF_EN
    logic [15:0]      perf_stall;
`endif

    modport slave (
        input  start, abort, a_in, b_in, acc_ready, loop_en_out,
        output loop_en, loop_bi, loop_a, acc_valid, acc_idx, busy, done, error
`ifdef INNER_SCHED_PERF_EN
        , output perf_stall
`endif
    );

    modport master (
        output start, abort, a_in, b_in, acc_ready, loop_en_out,
        input  loop_en, loop_bi, loop_a, acc_valid, acc_idx, busy, done, error
`ifdef INNER_SCHED_PERF_EN
        , input perf_stall
`endif
    );

endinterface

// File: rtl/inner_loop_sched_digit_shreg.sv
// Loadable operand shift register; presents the least-significant RADIX-bit digit and
// shifts by one digit per step, filling with zeros so the top digit is zero-padded.
module digit_shreg
    import inner_loop_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [OPW-1:0]   i_din,
    output logic [RADIX-1:0] o_dout
);

    logic [OPW-1:0] r_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_din;
        end else if (i_shift) begin
            r_sh <= r_sh >> RADIX;
        end
    end

    assign o_dout = r_sh[RADIX-1:0];

endmodule

// File: rtl/inner_loop_sched.sv
// Sequences the inner-loop multiplier over every RADIX-bit digit of b, with watchdog and abort flush.
// INNER_SCHED_PERF_EN adds perf_stall, the number of HOLD cycles in the current operation.
module inner_loop_sched
    import inner_loop_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    inner_loop_sched_if.slave bus
);

    sched_state_t     r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [FL_W-1:0]  r_fcnt;
    logic [OPW-1:0]   r_a;
    logic [RADIX-1:0] r_bi;
    logic             r_busy;
    logic             r_done;
    logic             w_load, w_issue, w_acc, w_err, w_last, w_flush_end;
    logic [RADIX-1:0] w_digit;

    // The shift register steps on issue, so its low digit is always the next one to send.
    digit_shreg u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_shift (w_issue),
        .i_din   (bus.b_in),
        .o_dout  (w_digit)
    );

    assign w_last      = (r_idx == IDX_W'(NDIG - 1));
    assign w_flush_end = (r_state == FLUSH) && (r_fcnt == FL_W'(LAT - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_issue = 1'b0;
        w_acc   = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.abort) begin
                    w_next = FLUSH;
                end else begin
                    w_issue = 1'b1;
                    w_next  = WAIT;
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    w_next = FLUSH;
                end else if (bus.loop_en_out) begin
                    w_acc = 1'b1;
                    if (w_last) begin
                        w_next = IDLE;
                    end else if (bus.acc_ready) begin
                        w_issue = 1'b1;
                    end else begin
                        w_next = HOLD;
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_err  = 1'b1;
                    w_next = FLUSH;
                end
            end
            HOLD: begin
                if (bus.abort) begin
                    w_next = FLUSH;
                end else if (bus.acc_ready) begin
                    w_next = ISSUE;
                end
            end
            FLUSH: begin
                if (w_flush_end) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // r_cnt counts cycles since the most recent loop_en; r_fcnt counts cycles spent in FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_fcnt <= '0;
            r_a    <= '0;
            r_bi   <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_acc && w_last;
            if (w_load) begin
                r_idx  <= '0;
                r_a    <= bus.a_in;
                r_busy <= 1'b1;
            end else if (w_acc && w_last) begin
                r_busy <= 1'b0;
            end else if (w_acc) begin
                r_idx <= r_idx + 1'b1;
            end else if (w_flush_end) begin
                r_busy <= 1'b0;
            end
            if (w_issue) begin
                r_bi  <= w_digit;
                r_cnt <= CNT_W'(1);
            end else if (r_state == WAIT && r_cnt != CNT_W'(TIMEOUT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_fcnt <= (r_state == FLUSH) ? r_fcnt + 1'b1 : '0;
        end
    end

`ifdef INNER_SCHED_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (w_load) begin
            r_stall <= '0;
        end else if (r_state == HOLD && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign bus.perf_stall = r_stall;
`endif

    assign bus.loop_en   = w_issue;
    assign bus.loop_bi   = w_issue ? w_digit : r_bi;
    assign bus.loop_a    = r_a;
    assign bus.acc_valid = w_acc;
    assign bus.acc_idx   = w_acc ? r_idx : '0;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = w_err;

endmodule

// File: tb/tb_inner_loop_sched.sv
// Randomized bench for inner_loop_sched: an inner-loop responder plus a digit-level
// scoreboard that predicts issue times, digits, results, done/error pulses and busy.
module tb_inner_loop_sched;
    import inner_loop_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inner_loop_sched_if bus();

    inner_loop_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int totalChecks = 0;
    int badChecks   = 0;

    // stimulus state
    int cyc = 0;
    int pendingAt = -1;
    int staleAt = -1;
    int lat = LAT;
    bit loopMute = 1'b0;
    bit randReady = 1'b0;
    int dropIdx = -1;
    int dropLen = 0;
    int dropLeft = 0;
    logic driveStart = 1'b0;
    logic driveAbort = 1'b0;
    logic driveReady = 1'b1;
    logic driveEnOut = 1'b0;
    logic [OPW-1:0] driveA = '0;
    logic [OPW-1:0] driveB = '0;

    // reference model state
    bit mBusy = 1'b0;
    bit acceptPending = 1'b0;
    bit expectResults = 1'b0;
    bit holdPending = 1'b0;
    int expEnCycle = -1;
    int expDone = -1;
    int expErr = -1;
    int expBusyFall = -1;
    int nextIssue = 0;
    int nextResult = 0;
    int expHold = 0;
    int startCycle = 0;
    int lastDoneCycle = 0;
    int doneCount = 0;
    int errCount = 0;
    logic [OPW-1:0]   expA = '0;
    logic [OPW-1:0]   expB = '0;
    logic [RADIX-1:0] topBi = '0;
    logic [RADIX-1:0] topExp;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got=stuck expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [RADIX-1:0] digitOf(input logic [OPW-1:0] b, input int k);
        logic [OPW-1:0] t;
        t = b >> (RADIX * k);
        return t[RADIX-1:0];
    endfunction

    function automatic logic [OPW-1:0] randomOperand();
        logic [OPW-1:0] v;
        v = '0;
        for (int i = 0; i < (OPW + 31) / 32; i++) v = (v << 32) | OPW'($urandom);
        return v;
    endfunction

    task automatic resetModel();
        mBusy = 0; acceptPending = 0; expectResults = 0; holdPending = 0;
        expEnCycle = -1; expDone = -1; expErr = -1; expBusyFall = -1;
        pendingAt = -1; staleAt = -1; dropLeft = 0;
    endtask

    task automatic observeCycle();
        if (acceptPending) begin
            mBusy = 1;
            acceptPending = 0;
        end
        if (cyc == expBusyFall) begin
            mBusy = 0;
            expBusyFall = -1;
        end
        if (driveAbort && mBusy) begin
            expectResults = 0; holdPending = 0; pendingAt = -1;
            expEnCycle = -1; expDone = -1; expErr = -1;
            expBusyFall = cyc + LAT;
        end
        checkOutput("busy", bus.busy, mBusy);
        if (holdPending) begin
            expHold++;
            if (driveReady) begin
                holdPending = 0;
                expEnCycle = cyc + 1;
            end
        end
        if (driveEnOut || bus.acc_valid) begin
            checkOutput("acc_valid", bus.acc_valid, driveEnOut && expectResults);
            if (bus.acc_valid) checkOutput("acc_idx", bus.acc_idx, nextResult);
        end
        if (driveEnOut && expectResults) begin
            nextResult++;
            if (nextResult == NDIG) begin
                expDone = cyc + 1;
                expBusyFall = cyc + 1;
                expectResults = 0;
            end else if (driveReady) begin
                expEnCycle = cyc;
            end else begin
                holdPending = 1;
            end
        end
        if (bus.loop_en) begin
            checkOutput("en_cycle", cyc, expEnCycle);
            checkOutput("loop_bi", bus.loop_bi, digitOf(expB, nextIssue));
            checkOutput("loop_a", bus.loop_a == expA, 1);
            if (nextIssue == NDIG - 1) topBi = bus.loop_bi;
            nextIssue++;
            expEnCycle = -1;
            if (loopMute) expErr = cyc + TIMEOUT;
            else pendingAt = cyc + lat;
        end else if (cyc == expEnCycle) begin
            checkOutput("en_missing", 0, 1);
            expEnCycle = -1;
        end
        if (bus.done || cyc == expDone) begin
            checkOutput("done", bus.done, cyc == expDone);
            if (bus.done) begin
                doneCount++;
                lastDoneCycle = cyc;
            end
        end
        if (bus.error || cyc == expErr) begin
            checkOutput("error", bus.error, cyc == expErr);
            if (bus.error) errCount++;
        end
        if (cyc == expErr) begin
            expectResults = 0;
            expBusyFall = cyc + LAT;
            expErr = -1;
        end
        if (driveStart && !mBusy) begin
            acceptPending = 1;
            expA = driveA; expB = driveB;
            nextIssue = 0; nextResult = 0; expHold = 0;
            expEnCycle = cyc + 1;
            expectResults = 1;
            startCycle = cyc;
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        cyc++;
        driveEnOut = (pendingAt == cyc) || (staleAt == cyc);
        if (dropLeft > 0) begin
            driveReady = 1'b0;
            dropLeft--;
        end else if (driveEnOut && expectResults && nextResult == dropIdx) begin
            driveReady = 1'b0;
            dropLeft = dropLen - 1;
        end else begin
            driveReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        bus.start = driveStart;
        bus.abort = driveAbort;
        bus.a_in = driveA;
        bus.b_in = driveB;
        bus.acc_ready = driveReady;
        bus.loop_en_out = driveEnOut;
        #1;
        observeCycle();
    endtask

    task automatic applyStimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        driveA = a;
        driveB = b;
        driveStart = 1'b1;
        stepCycle();
        driveStart = 1'b0;
    endtask

    task automatic runUntilIdle(input int budget);
        bit fin;
        fin = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            stepCycle();
            fin = !mBusy && !acceptPending;
        end
        if (!fin) checkOutput("op_budget", 0, 1);
    endtask

    task automatic checkIdleOutputs(input string pfx);
        checkOutput({pfx, "_loop_en"}, bus.loop_en, 0);
        checkOutput({pfx, "_acc_valid"}, bus.acc_valid, 0);
        checkOutput({pfx, "_acc_idx"}, bus.acc_idx, 0);
        checkOutput({pfx, "_busy"}, bus.busy, 0);
        checkOutput({pfx, "_done"}, bus.done, 0);
        checkOutput({pfx, "_error"}, bus.error, 0);
        checkOutput({pfx, "_loop_bi"}, bus.loop_bi, 0);
        checkOutput({pfx, "_loop_a_zero"}, bus.loop_a == '0, 1);
`ifdef INNER_SCHED_PERF_EN
        checkOutput({pfx, "_perf"}, bus.perf_stall, 0);
`endif
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.a_in = '0; bus.b_in = '0;
        bus.acc_ready = 1; bus.loop_en_out = 0;
        topExp = {{(RADIX - 32){1'b0}}, 32'hFFFF_FFFF};

        // reset state
        repeat (3) stepCycle();
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        stepCycle();

        // nominal run
        $display("[TB] nominal a=5 b=1");
        doneCount = 0;
        applyStimulus(OPW'(5), OPW'(1));
        runUntilIdle(400);
        checkOutput("nom_results", nextResult, 40);
        checkOutput("nom_latency", lastDoneCycle - startCycle, 162);
        checkOutput("nom_done_count", doneCount, 1);
`ifdef INNER_SCHED_PERF_EN
        checkOutput("nom_perf", bus.perf_stall, 0);
`endif

        // backpressure after digit 3
        $display("[TB] backpressure");
        dropIdx = 3; dropLen = 10;
        applyStimulus(randomOperand(), randomOperand());
        runUntilIdle(400);
        dropIdx = -1;
        checkOutput("bp_results", nextResult, 40);
        checkOutput("bp_latency", lastDoneCycle - startCycle, 173);
        repeat (5) stepCycle();
`ifdef INNER_SCHED_PERF_EN
        checkOutput("bp_perf", bus.perf_stall, 10);
`endif

        // timeout
        $display("[TB] timeout");
        loopMute = 1; errCount = 0; doneCount = 0;
        applyStimulus(randomOperand(), randomOperand());
        runUntilIdle(100);
        loopMute = 0;
        checkOutput("to_err_count", errCount, 1);
        checkOutput("to_results", nextResult, 0);
        checkOutput("to_done_count", doneCount, 0);

        // abort in WAIT at idx 7, stale en_out, start during flush
        $display("[TB] abort");
        doneCount = 0;
        applyStimulus(randomOperand(), randomOperand());
        for (int i = 0; i < 100 && nextIssue < 8; i++) stepCycle();
        driveAbort = 1'b1;
        stepCycle();
        driveAbort = 1'b0;
        staleAt = cyc + 2;
        stepCycle();
        driveStart = 1'b1;
        stepCycle();
        driveStart = 1'b0;
        runUntilIdle(50);
        repeat (8) stepCycle();
        staleAt = -1;
        checkOutput("ab_results", nextResult, 7);
        checkOutput("ab_done_count", doneCount, 0);
        checkOutput("ab_issued", nextIssue, 8);

        // asynchronous reset mid-operation
        $display("[TB] reset mid-op");
        applyStimulus(randomOperand(), randomOperand());
        for (int i = 0; i < 200 && nextIssue < 21; i++) stepCycle();
        #2 rst_n = 1'b0;
        #1;
        checkIdleOutputs("midrst");
        resetModel();
        repeat (2) stepCycle();
        rst_n = 1'b1;
        stepCycle();
        applyStimulus(randomOperand(), randomOperand());
        runUntilIdle(400);
        checkOutput("rst_results", nextResult, 40);
        checkOutput("rst_latency", lastDoneCycle - startCycle, 162);

        // all-ones b, start pulsed while busy
        $display("[TB] top digit");
        applyStimulus(randomOperand(), '1);
        repeat (50) stepCycle();
        driveB = '0;
        driveStart = 1'b1;
        stepCycle();
        driveStart = 1'b0;
        runUntilIdle(400);
        checkOutput("top_digit", topBi, topExp);
        checkOutput("top_results", nextResult, 40);
        checkOutput("top_latency", lastDoneCycle - startCycle, 162);

        // randomized latency and accumulator backpressure
        $display("[TB] random ops");
        randReady = 1;
        for (int n = 0; n < 6; n++) begin
            lat = $urandom_range(1, 8);
            applyStimulus(randomOperand(), randomOperand());
            runUntilIdle(3000);
            checkOutput("rnd_results", nextResult, 40);
`ifdef INNER_SCHED_PERF_EN
            checkOutput("rnd_perf", bus.perf_stall, expHold);
`endif
        end
        randReady = 0;
        lat = LAT;
        repeat (3) stepCycle();

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
